lfsr_seq_ctrl: RTL
==================

# lfsr_seq_ctrl

Command-driven sequencer for the team's 8-bit Fibonacci LFSR. Accepts a seed and word count, loads and steps the LFSR, packs its serial output MSB-first into WORD_W-bit words, and delivers them on a valid/ready stream with backpressure. The block sits between a host command port and any consumer of pseudo-random words, such as pattern generators or scramblers.

## Interface
Parameters:
- WORD_W, default 8: bits packed per output word (LFSR shifts per word); legal range 1..16.
- LEN_W, default 8: width of the word-count field.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous and active-low.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_seed  in  8  LFSR seed, captured on handshake.
- cmd_len  in  LEN_W  words to emit, captured on handshake.
- out_valid  out  1  word available.
- out_ready  in  1  consumer accepts the word.
- out_data  out  WORD_W  packed word.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse when a command completes.
- lockup  out  1  one-cycle pulse on zero-seed substitution. Driven only when LFSR_SEQ_CTRL_LOCKUP_EN is defined; otherwise tied 0.

## Operation
- LFSR state s[7:0], polynomial x^8+x^6+x^5+x^4+1.
  - Feedback: f = s[7]^s[5]^s[4]^s[3].
  - Next state: {s[6:0], f}.
  - Serial bit: s[7].
  - Period is 255 for a nonzero state.
- FSM states are IDLE, LOAD, SHIFT, EMIT and DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture seed and length.
  - Go to DONE if cmd_len==0; otherwise go to LOAD.
- LOAD: s <= seed, bit counter <= 0; go to SHIFT.
- SHIFT:
  - Each cycle, shreg <= {shreg[WORD_W-2:0], s[7]} and the LFSR advances.
  - After WORD_W shifts, latch shreg into out_data and go to EMIT.
- EMIT:
  - out_valid=1. LFSR and out_data are frozen.
  - On out_ready, decrement words_left.
  - Go to DONE if words_left reaches 0; otherwise go to SHIFT.
- DONE: done=1 for one cycle; go to IDLE.
- Commands offered while busy are not accepted (cmd_ready=0) and have no effect.
- LFSR state persists across commands, but every command reloads it from its seed.
- Word-count arithmetic is unsigned LEN_W bits; no wrap, because the count stops at 0.

## Timing
- Reset values:
  - State is IDLE; s=0x00; words_left=0.
  - cmd_ready=0 while rst_n is low and 1 from the first cycle after release.
  - out_valid=0, out_data=0, busy=0, done=0, lockup=0.
- Latency, with the handshake at edge T:
  - LOAD during cycle T+1.
  - SHIFT during T+2 .. T+1+WORD_W.
  - First out_valid in cycle T+2+WORD_W.
- Each subsequent word arrives WORD_W+1 cycles after the previous acceptance, counting from the cycle after out_ready.
- With out_ready held high, throughput is one word per WORD_W+1 cycles.
- Handshake rule: out_data and out_valid stay stable while out_valid && !out_ready.
- A zero-length command gives done exactly 2 cycles after the handshake, and out_valid never asserts.
- Reset mid-operation: asynchronous return to the reset values, and any pending word is discarded.

## Configuration
Macro: LFSR_SEQ_CTRL_LOCKUP_EN.
- Defined: a zero seed in LOAD is replaced by DEFAULT_SEED (0x01), and lockup pulses in that LOAD cycle.
- Undefined:
  - A zero seed is loaded as-is, and all words are 0.
  - No substitution occurs; lockup is constant 0.

## Structure
- Package lfsr_seq_ctrl_pkg holds:
  - the FSM state enum;
  - LFSR_W=8;
  - tap mask 8'hB8;
  - DEFAULT_SEED=8'h01.
- Sub-module lfsr8_core holds the register and feedback, with ports clk, rst_n, load, seed, shift_en, state, bit_out.
- The top module holds the FSM, packing register and counters.

## Test plan
- Seed 0x01, len 3, WORD_W=8, out_ready=1 -> words 0x01, 0x1C, 0x4B; done once, 2 cycles after the last word is accepted.
- Timing check: handshake at T -> out_valid first high in cycle T+10; words spaced 9 cycles; busy low in the cycle after done.
- Seed 0x01, len 2, out_ready held low for 5 cycles on the first word -> 0x01 held stable; the second word is still 0x1C.
- cmd_len=0 -> no out_valid; done 2 cycles after the handshake. A second cmd_valid during busy -> ignored, and cmd_ready stays 0.
- Seed 0x00, len 2:
  - with LFSR_SEQ_CTRL_LOCKUP_EN defined -> lockup pulse, then words 0x01, 0x1C;
  - without it -> words 0x00, 0x00, lockup=0.
- rst_n pulsed low during SHIFT of word 2 -> all outputs return to reset values asynchronously; a new command (seed 0x01, len 1) then gives 0x01.

Source files
------------

// File: rtl/lfsr_seq_ctrl_pkg.sv
// Shared types, constants and the feedback helper for the LFSR word sequencer.
package lfsr_seq_ctrl_pkg;

  localparam int                LFSR_W       = 8;
  // Taps for x^8+x^6+x^5+x^4+1 in the MSB-out orientation: bits 7, 5, 4, 3.
  localparam logic [LFSR_W-1:0] TAP_MASK     = 8'hB8;
  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 8'h01;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    EMIT  = 3'd3,
    DONE  = 3'd4
  } seq_state_t;

  function automatic logic lfsr_feedback(input logic [LFSR_W-1:0] s);
    return ^(s & TAP_MASK);
  endfunction

endpackage

// File: rtl/lfsr8_core.sv
// 8-bit Fibonacci LFSR register: load has priority over shift, serial bit is the MSB.
module lfsr8_core
  import lfsr_seq_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              shift_en,
  output logic [LFSR_W-1:0] state,
  output logic              bit_out
);

  logic [LFSR_W-1:0] state_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= '0;
    end else if (load) begin
      state_reg <= seed;
    end else if (shift_en) begin
      state_reg <= {state_reg[LFSR_W-2:0], lfsr_feedback(state_reg)};
    end
  end

  assign state   = state_reg;
  assign bit_out = state_reg[LFSR_W-1];

endmodule

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven LFSR word sequencer with a valid/ready word stream.
// Optional zero-seed substitution and lockup pulse: define LFSR_SEQ_CTRL_LOCKUP_EN.
module lfsr_seq_ctrl
  import lfsr_seq_ctrl_pkg::*;
#(
  parameter int WORD_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LFSR_W-1:0] cmd_seed,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              lockup
);

  localparam int CNT_W = 5;

  seq_state_t        state_reg;
  seq_state_t        state_next;
  logic [LFSR_W-1:0] seed_reg;
  logic [LFSR_W-1:0] load_seed;
  logic [LFSR_W-1:0] lfsr_state;
  logic [LEN_W-1:0]  words_left_reg;
  logic [CNT_W-1:0]  bit_cnt_reg;
  logic [WORD_W-1:0] shreg_reg;
  logic [WORD_W-1:0] shreg_next;
  logic [WORD_W-1:0] out_data_reg;
  logic              done_reg;
  logic              cmd_fire;
  logic              word_full;
  logic              core_load;
  logic              core_shift;
  logic              serial_bit;
  logic              lfsr_state_unused;

  // Gated by rst_n so no command can be offered while reset is held.
  assign cmd_ready = rst_n && (state_reg == IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign busy      = (state_reg != IDLE);
  assign out_valid = (state_reg == EMIT);
  assign out_data  = out_data_reg;
  assign done      = done_reg;
  assign word_full = (state_reg == SHIFT) && (bit_cnt_reg == CNT_W'(WORD_W - 1));

`ifdef LFSR_SEQ_CTRL_LOCKUP_EN
  assign load_seed = (seed_reg == '0) ? DEFAULT_SEED : seed_reg;
  assign lockup    = (state_reg == LOAD) && (seed_reg == '0);
`else
  assign load_seed = seed_reg;
  assign lockup    = 1'b0;
`endif

  generate
    if (WORD_W == 1) begin : g_pack_single
      assign shreg_next = serial_bit;
    end else begin : g_pack_multi
      assign shreg_next = {shreg_reg[WORD_W-2:0], serial_bit};
    end
  endgenerate

  lfsr8_core u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (core_load),
    .seed     (load_seed),
    .shift_en (core_shift),
    .state    (lfsr_state),
    .bit_out  (serial_bit)
  );

  // Only the serial MSB stream is consumed; the parallel state is left for debug taps.
  assign lfsr_state_unused = ^lfsr_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    core_load  = 1'b0;
    core_shift = 1'b0;
    unique case (state_reg)
      IDLE: begin
        if (cmd_fire) begin
          state_next = (cmd_len == '0) ? DONE : LOAD;
        end
      end
      LOAD: begin
        core_load  = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        core_shift = 1'b1;
        if (word_full) begin
          state_next = EMIT;
        end
      end
      EMIT: begin
        if (out_ready) begin
          state_next = (words_left_reg == LEN_W'(1)) ? DONE : SHIFT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // done is registered off the DONE state, so it lands in the first IDLE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seed_reg       <= '0;
      words_left_reg <= '0;
      bit_cnt_reg    <= '0;
      shreg_reg      <= '0;
      out_data_reg   <= '0;
      done_reg       <= 1'b0;
    end else begin
      done_reg <= (state_reg == DONE);
      unique case (state_reg)
        IDLE: begin
          if (cmd_fire) begin
            seed_reg       <= cmd_seed;
            words_left_reg <= cmd_len;
          end
        end
        LOAD: begin
          bit_cnt_reg <= '0;
          shreg_reg   <= '0;
        end
        SHIFT: begin
          shreg_reg <= shreg_next;
          if (word_full) begin
            out_data_reg <= shreg_next;
            bit_cnt_reg  <= '0;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
        end
        EMIT: begin
          if (out_ready) begin
            words_left_reg <= words_left_reg - LEN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
